// File: rtl/alu_issue_stage.sv
// Execute-stage ALU issue unit: decodes RV32I ALU/address/link ops into an ALU control word and operands (S1),
// then captures the ALU result into a result stage (S2). Accept-to-out_valid is two edges; S1 and S2 stall together under back-pressure.
module alu_issue_stage #(
  parameter int XLEN        = 32,
  parameter int LINK_OFFSET = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [5:0]      ALU_Control,
  output logic [XLEN-1:0] operand_A,
  output logic [XLEN-1:0] operand_B,
  input  logic [XLEN-1:0] ALU_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic            s1_valid;
  logic            s1_illegal;
  logic            s2_valid;
  logic            s1_advance;
  logic            accept;

  logic [5:0]      dec_ctrl;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_illegal;
  logic            dec_alt;

  assign s1_advance = s1_valid && (!s2_valid || out_ready);
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;
  assign out_valid  = s2_valid;

  // Anything not handled here issues ADD of zeros so the ALU sees a quiet, known input.
  always_comb begin
    dec_ctrl    = 6'b000000;
    dec_a       = '0;
    dec_b       = '0;
    dec_illegal = 1'b0;
    dec_alt     = 1'b0;
    case (opcode)
      OP_R: begin
        if (|(funct7 & 7'b1011111)) begin
          dec_illegal = 1'b1;
        end else begin
          dec_alt  = funct7[5] && (funct3 == 3'b000 || funct3 == 3'b101);
          dec_ctrl = {2'b00, dec_alt, funct3};
          dec_a    = rs1_data;
          dec_b    = rs2_data;
        end
      end
      OP_I: begin
        dec_alt  = funct7[5] && (funct3 == 3'b101);
        dec_ctrl = {2'b00, dec_alt, funct3};
        dec_a    = rs1_data;
        dec_b    = imm;
      end
      OP_LUI: begin
        dec_b = imm;
      end
      OP_AUIPC: begin
        dec_a = pc;
        dec_b = imm;
      end
      OP_LOAD, OP_STORE: begin
        dec_a = rs1_data;
        dec_b = imm;
      end
      OP_JAL, OP_JALR: begin
        dec_a = pc;
        dec_b = XLEN'(LINK_OFFSET);
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_illegal  <= 1'b0;
      ALU_Control <= '0;
      operand_A   <= '0;
      operand_B   <= '0;
    end else begin
      if (accept) begin
        s1_valid    <= 1'b1;
        s1_illegal  <= dec_illegal;
        ALU_Control <= dec_ctrl;
        operand_A   <= dec_a;
        operand_B   <= dec_b;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      result   <= '0;
      illegal  <= 1'b0;
    end else begin
      if (s1_advance) begin
        s2_valid <= 1'b1;
        result   <= s1_illegal ? '0 : ALU_result;
        illegal  <= s1_illegal;
      end else if (s2_valid && out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule
